// File: rtl/data_path_pkg.sv
// Shared types and constants for the serial-channel transmit data path.
//   state_t      : controller state (UNLINKED, IDLE, BUSY)
//   cmd_t        : latched command being transmitted
//   P_*          : (bitt1,bitt2) wire patterns for one slot
//   slot_count   : number of slots a command occupies (1 or 2)
//   slot_pattern : wire pattern for a given command and slot index
package data_path_pkg;

    typedef enum logic [1:0] {UNLINKED, IDLE, BUSY} state_t;

    localparam logic [1:0] P_ZERO = 2'b10;
    localparam logic [1:0] P_ONE  = 2'b01;
    localparam logic [1:0] P_FLAG = 2'b11;

    typedef enum logic [2:0] {CMD_FS, CMD_FD, CMD_FE, CMD_0, CMD_1} cmd_t;

    function automatic logic [1:0] slot_count(input cmd_t c);
        case (c)
            CMD_FS, CMD_FD, CMD_FE: return 2'd2;
            default:                return 2'd1;
        endcase
    endfunction

    // Frame symbols open with a flag slot; the second slot tells them apart.
    function automatic logic [1:0] slot_pattern(input cmd_t c, input logic slot);
        if (!slot) begin
            case (c)
                CMD_0:   return P_ZERO;
                CMD_1:   return P_ONE;
                default: return P_FLAG;
            endcase
        end else begin
            case (c)
                CMD_FS:  return P_ZERO;
                CMD_FD:  return P_ONE;
                default: return P_FLAG;
            endcase
        end
    endfunction

endpackage

// File: rtl/data_path_slot_timer.sv
// Slot timer: one slot is SYM_CYCLES of drive followed by GAP_CYCLES of gap.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : (re)load the timer for a fresh slot
//   abort        : clear the timer
//   drive_phase  : high while the slot pattern should be driven
//   slot_done    : high in the last cycle of the slot
module data_path_slot_timer #(
    parameter int SYM_CYCLES = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic drive_phase,
    output logic slot_done
);
    localparam int TOTAL = SYM_CYCLES + GAP_CYCLES;
    localparam int CW    = $clog2(TOTAL + 1);

    logic [CW-1:0] cnt;

    // Down-counter; zero means idle. Start wins over the terminal count so a
    // following slot can begin without a dead cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(TOTAL);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign drive_phase = (cnt > CW'(GAP_CYCLES));
    assign slot_done   = (cnt == CW'(1));

endmodule

// File: rtl/data_path.sv
// Transmit data path of a two-wire return-to-zero serial channel. Turns
// single-cycle command pulses into timed symbol patterns on bitt1/bitt2 and
// pulses ackt once a symbol has been completely sent.
// Ports:
//   clk, rst_n              : clock, synchronous active-low reset
//   X0                      : link init / abort
//   Fs, Fd, Fe, nought, one : symbol requests (priority in that order)
//   ackt                    : one-cycle symbol-complete pulse
//   bitt1, bitt2            : registered channel wires
//
// state    | meaning
// UNLINKED | after reset; only X0 is honoured
// IDLE     | linked, waiting for a command
// BUSY     | sending the latched command slot by slot
module data_path
    import data_path_pkg::*;
#(
    parameter int SYM_CYCLES = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic X0,
    input  logic Fs,
    input  logic Fd,
    input  logic Fe,
    input  logic nought,
    input  logic one,
    output logic ackt,
    output logic bitt1,
    output logic bitt2
);
    state_t     state, state_nxt;
    cmd_t       cmd_q, cmd_nxt, req_cmd;
    logic       req_valid;
    logic       slot_idx, slot_nxt;
    logic       last_q, last_nxt;
    logic       ackt_nxt;
    logic [1:0] wire_nxt;
    logic       tmr_start, tmr_abort, drive_phase, slot_done;

    always_comb begin
        req_valid = 1'b1;
        req_cmd   = CMD_FS;
        if (Fs)          req_cmd = CMD_FS;
        else if (Fd)     req_cmd = CMD_FD;
        else if (Fe)     req_cmd = CMD_FE;
        else if (nought) req_cmd = CMD_0;
        else if (one)    req_cmd = CMD_1;
        else             req_valid = 1'b0;
    end

    data_path_slot_timer #(
        .SYM_CYCLES(SYM_CYCLES),
        .GAP_CYCLES(GAP_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (tmr_start),
        .abort      (tmr_abort),
        .drive_phase(drive_phase),
        .slot_done  (slot_done)
    );

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        slot_nxt  = slot_idx;
        last_nxt  = 1'b0;
        ackt_nxt  = 1'b0;
        wire_nxt  = 2'b00;
        tmr_start = 1'b0;
        tmr_abort = 1'b0;
        case (state)
            UNLINKED: begin
                if (X0) state_nxt = IDLE;
            end
            IDLE: begin
                if (X0) begin
                    tmr_abort = 1'b1;
                end else if (req_valid) begin
                    state_nxt = BUSY;
                    cmd_nxt   = req_cmd;
                    slot_nxt  = 1'b0;
                    tmr_start = 1'b1;
                end
            end
            BUSY: begin
                if (X0) begin
                    state_nxt = IDLE;
                    tmr_abort = 1'b1;
                end else if (last_q) begin
                    // Wires trail the timer by one register, so the ack
                    // waits one cycle past the final slot_done.
                    state_nxt = IDLE;
                    ackt_nxt  = 1'b1;
                end else begin
                    if (drive_phase) wire_nxt = slot_pattern(cmd_q, slot_idx);
                    if (slot_done) begin
                        if (!slot_idx && slot_count(cmd_q) == 2'd2) begin
                            slot_nxt  = 1'b1;
                            tmr_start = 1'b1;
                        end else begin
                            last_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = UNLINKED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= UNLINKED;
            cmd_q    <= CMD_FS;
            slot_idx <= 1'b0;
            last_q   <= 1'b0;
            ackt     <= 1'b0;
            bitt1    <= 1'b0;
            bitt2    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd_q    <= cmd_nxt;
            slot_idx <= slot_nxt;
            last_q   <= last_nxt;
            ackt     <= ackt_nxt;
            bitt1    <= wire_nxt[1];
            bitt2    <= wire_nxt[0];
        end
    end

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
    logic clk = 1'b0;
    logic rst_n, X0, Fs, Fd, Fe, nought, one;
    logic ackt, bitt1, bitt2;
    int   errors = 0;
    int   checks = 0;

    data_path dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X0    (X0),
        .Fs    (Fs),
        .Fd    (Fd),
        .Fe    (Fe),
        .nought(nought),
        .one   (one),
        .ackt  (ackt),
        .bitt1 (bitt1),
        .bitt2 (bitt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: {ackt,bitt1,bitt2} got %b expected %b", tag, obs, exp);
        end
    endtask

    // v = {X0,Fs,Fd,Fe,nought,one}; call at a negedge, returns in cycle n
    task automatic pulse(input logic [5:0] v);
        {X0, Fs, Fd, Fe, nought, one} = v;
        @(negedge clk);
        {X0, Fs, Fd, Fe, nought, one} = 6'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk(tag, {ackt, bitt1, bitt2}, 3'b000);
        end
    endtask

    // Default timing: slot = 4 drive + 4 gap, ack one cycle after the last gap.
    task automatic expect_sym(input string tag, input logic [1:0] p0,
                              input logic [1:0] p1, input int nslots);
        logic [2:0] e;
        for (int k = 1; k <= nslots * 8 + 1; k++) begin
            @(negedge clk);
            if (k == nslots * 8 + 1) e = 3'b100;
            else if (((k - 1) % 8) < 4) e = {1'b0, (((k - 1) / 8) == 0) ? p0 : p1};
            else e = 3'b000;
            chk(tag, {ackt, bitt1, bitt2}, e);
        end
    endtask

    initial begin
        logic [2:0] e;
        rst_n = 1'b0;
        {X0, Fs, Fd, Fe, nought, one} = 6'b0;
        repeat (2) @(negedge clk);
        chk("reset", {ackt, bitt1, bitt2}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);

        // Unlinked: Fs ignored
        pulse(6'b010000);
        idle_check("unlinked_fs", 40);

        // Link, then nought
        pulse(6'b100000);
        chk("x0_link", {ackt, bitt1, bitt2}, 3'b000);
        pulse(6'b000010);
        expect_sym("nought", 2'b10, 2'b00, 1);

        // Back-to-back frame symbols, each issued in the previous ack cycle
        pulse(6'b000100);
        expect_sym("fe", 2'b11, 2'b11, 2);
        pulse(6'b010000);
        expect_sym("fs", 2'b11, 2'b10, 2);
        pulse(6'b001000);
        expect_sym("fd", 2'b11, 2'b01, 2);

        // Priority: Fd beats one, one is not queued
        pulse(6'b001001);
        expect_sym("prio_fd", 2'b11, 2'b01, 2);
        idle_check("prio_no_bit", 12);

        // Priority: X0 beats Fs
        pulse(6'b110000);
        idle_check("prio_x0", 10);

        // one, then nought while busy -> dropped
        pulse(6'b000001);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 3) nought = 1'b0;
            e = (k == 9) ? 3'b100 : (k <= 4) ? 3'b001 : 3'b000;
            chk("busy_drop", {ackt, bitt1, bitt2}, e);
            if (k == 2) nought = 1'b1;
        end
        idle_check("busy_drop_after", 12);

        // Fs aborted by X0 sampled at n+6
        pulse(6'b010000);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) X0 = 1'b0;
            e = (k <= 4) ? 3'b011 : 3'b000;
            chk("abort", {ackt, bitt1, bitt2}, e);
            if (k == 5) X0 = 1'b1;
        end
        pulse(6'b000001);
        expect_sym("after_abort", 2'b01, 2'b00, 1);

        // X0 in the ack cycle: ack already out, link stays up
        pulse(6'b100000);
        chk("x0_ack_cycle", {ackt, bitt1, bitt2}, 3'b000);
        pulse(6'b001000);
        expect_sym("fd_after_x0", 2'b11, 2'b01, 2);

        // Reset mid-symbol
        pulse(6'b000100);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("pre_reset", {ackt, bitt1, bitt2}, 3'b011);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset", {ackt, bitt1, bitt2}, 3'b000);
        rst_n = 1'b1;
        pulse(6'b000001);
        idle_check("unlinked_after_reset", 12);
        pulse(6'b100000);
        pulse(6'b000010);
        expect_sym("relinked", 2'b10, 2'b00, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
